// File: rtl/nn_pkg.sv
// nn_pkg
// Shared definitions for the classifier back end: the Q16.16 unit constant,
// the 32-bit fixed-point word type, the loss-stage state encoding and a
// ReLU helper used when forward beats are captured.
package nn_pkg;

  // 1.0 in Q16.16
  localparam logic [31:0] ONE = 32'h0001_0000;

  // 32-bit two's-complement Q16.16 word; arithmetic on it wraps
  typedef logic [31:0] q16_16_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Clamp negative Q16.16 values to zero
  function automatic q16_16_t relu(input q16_16_t v);
    q16_16_t r;
    if (v[31]) begin
      r = 32'h0000_0000;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker
// Keeps the running maximum of the values offered on update_i together with
// the index it arrived on. Ties keep the earlier (lower) index because only a
// strictly larger value replaces the stored one.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   clear_i       restart tracking (max = 0, index = 0)
//   update_i      offer value_i / idx_i this cycle
//   value_i       candidate value (already ReLU'd, so never negative)
//   idx_i         index of the candidate
//   max_idx_o     index of the largest value seen since the last clear
module argmax_tracker
  import nn_pkg::*;
#(
  parameter int IDX_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 update_i,
  input  q16_16_t              value_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic [IDX_WIDTH-1:0] max_idx_o
);

  q16_16_t              max_val_q;
  logic [IDX_WIDTH-1:0] max_idx_q;

  // Running maximum; unsigned compare is valid because inputs are ReLU'd
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      max_val_q <= 32'h0000_0000;
      max_idx_q <= {IDX_WIDTH{1'b0}};
    end else if (update_i && (value_i > max_val_q)) begin
      max_val_q <= value_i;
      max_idx_q <= idx_i;
    end
  end

  assign max_idx_o = max_idx_q;

endmodule

// File: rtl/fc_loss_stage.sv
// fc_loss_stage
// Terminal stage of the classifier pipeline. Collects the fully-connected
// layer's forward output (ReLU on capture), tracks the argmax, then drives the
// layer in backprop mode with the Q16.16 error vector output - onehot(label),
// drains the layer's backward stream and reports the prediction.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   label, label_valid   class label and start-of-sample strobe (IDLE only)
//   s_data/s_idx/s_valid forward (and discarded backward) stream from layer
//   s_rdy                ready back to the layer's out_rdy
//   m_data/m_idx         error vector to the layer's fc_input / fc_input_idx
//   m_rdy                the layer's in_rdy
//   fwd                  layer forward-mode select
//   pred, correct_cnt    last argmax and running count of correct samples
//   done                 one-cycle pulse at sample completion
//   proto_err            sticky: a forward beat arrived out of order
module fc_loss_stage
  import nn_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 10,
  parameter int IDX_WIDTH    = 10,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_WIDTH-1:0] label,
  input  logic                 label_valid,
  input  logic [31:0]          s_data,
  input  logic [IDX_WIDTH-1:0] s_idx,
  input  logic                 s_valid,
  output logic                 s_rdy,
  output logic [31:0]          m_data,
  output logic [IDX_WIDTH-1:0] m_idx,
  input  logic                 m_rdy,
  output logic                 fwd,
  output logic [IDX_WIDTH-1:0] pred,
  output logic [CNT_WIDTH-1:0] correct_cnt,
  output logic                 done,
  output logic                 proto_err
);

  localparam int AW = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0] DEPTH    = IDX_WIDTH'(OUTPUT_WIDTH);
  localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q;
  q16_16_t              obuf_q [OUTPUT_WIDTH];
  logic [IDX_WIDTH-1:0] k_q;
  logic [IDX_WIDTH-1:0] label_q;
  logic                 seen_low_q;
  logic                 s_rdy_q;
  logic                 fwd_q;
  q16_16_t              m_data_q;
  logic [IDX_WIDTH-1:0] m_idx_q;
  logic [IDX_WIDTH-1:0] pred_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 done_q;
  logic                 proto_err_q;

  logic                 accept_d;
  logic                 in_range_d;
  q16_16_t              relu_d;
  q16_16_t              err_d;
  logic                 trk_clear_d;
  logic                 trk_update_d;
  logic [IDX_WIDTH-1:0] trk_max_idx;

  // Beat acceptance, ReLU'd capture value and the error word for index k
  always_comb begin
    accept_d     = 1'b0;
    in_range_d   = 1'b0;
    relu_d       = 32'h0000_0000;
    err_d        = 32'h0000_0000;
    trk_clear_d  = 1'b0;
    trk_update_d = 1'b0;
    accept_d     = (state_q == ST_COLLECT) && s_valid && s_rdy_q;
    // Out-of-range indices are flagged as protocol errors but never written
    in_range_d   = (s_idx < DEPTH);
    relu_d       = relu(s_data);
    trk_clear_d  = (state_q == ST_IDLE) && label_valid;
    trk_update_d = accept_d && in_range_d;
    // Subtraction wraps; a negative result is a legal Q16.16 error
    if (k_q == label_q) begin
      err_d = obuf_q[k_q[AW-1:0]] - ONE;
    end else begin
      err_d = obuf_q[k_q[AW-1:0]];
    end
  end

  argmax_tracker #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_argmax (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (trk_clear_d),
    .update_i  (trk_update_d),
    .value_i   (relu_d),
    .idx_i     (s_idx),
    .max_idx_o (trk_max_idx)
  );

  // Sample sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= IDX_ZERO;
      label_q     <= IDX_ZERO;
      seen_low_q  <= 1'b0;
      s_rdy_q     <= 1'b0;
      fwd_q       <= 1'b1;
      m_data_q    <= 32'h0000_0000;
      m_idx_q     <= LAST_IDX;
      pred_q      <= IDX_ZERO;
      cnt_q       <= {CNT_WIDTH{1'b0}};
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < OUTPUT_WIDTH; i++) begin
        obuf_q[i] <= 32'h0000_0000;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          fwd_q   <= 1'b1;
          s_rdy_q <= 1'b0;
          if (label_valid) begin
            label_q <= label;
            k_q     <= IDX_ZERO;
            s_rdy_q <= 1'b1;
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept_d) begin
            if (in_range_d) begin
              obuf_q[s_idx[AW-1:0]] <= relu_d;
            end
            if (s_idx != k_q) begin
              proto_err_q <= 1'b1;
            end
            // The last class index ends collection regardless of order
            if (s_idx == LAST_IDX) begin
              k_q     <= IDX_ZERO;
              s_rdy_q <= 1'b0;
              fwd_q   <= 1'b0;
              state_q <= ST_EMIT;
            end else begin
              k_q <= k_q + IDX_ONE;
            end
          end
        end
        ST_EMIT: begin
          // m_* and k only move when the layer can take a beat
          if (m_rdy) begin
            m_idx_q  <= k_q;
            m_data_q <= err_d;
            if (k_q == LAST_IDX) begin
              k_q        <= IDX_ZERO;
              seen_low_q <= 1'b0;
              s_rdy_q    <= 1'b1;
              state_q    <= ST_DRAIN;
            end else begin
              k_q <= k_q + IDX_ONE;
            end
          end
        end
        ST_DRAIN: begin
          // The layer drops in_rdy while it runs backprop; wait for it to return
          if (!m_rdy) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            seen_low_q <= 1'b0;
            done_q     <= 1'b1;
            pred_q     <= trk_max_idx;
            if (trk_max_idx == label_q) begin
              cnt_q <= cnt_q + CNT_ONE;
            end
            fwd_q   <= 1'b1;
            s_rdy_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_rdy       = s_rdy_q;
  assign fwd         = fwd_q;
  assign m_data      = m_data_q;
  assign m_idx       = m_idx_q;
  assign pred        = pred_q;
  assign correct_cnt = cnt_q;
  assign done        = done_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_fc_loss_stage.sv
module tb_fc_loss_stage;

  localparam int OW = 10;
  localparam int IW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] label;
  logic          label_valid;
  logic [31:0]   s_data;
  logic [IW-1:0] s_idx;
  logic          s_valid;
  logic          s_rdy;
  logic [31:0]   m_data;
  logic [IW-1:0] m_idx;
  logic          m_rdy;
  logic          fwd;
  logic [IW-1:0] pred;
  logic [CW-1:0] correct_cnt;
  logic          done;
  logic          proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_loss_stage #(
    .OUTPUT_WIDTH (OW),
    .IDX_WIDTH    (IW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .label       (label),
    .label_valid (label_valid),
    .s_data      (s_data),
    .s_idx       (s_idx),
    .s_valid     (s_valid),
    .s_rdy       (s_rdy),
    .m_data      (m_data),
    .m_idx       (m_idx),
    .m_rdy       (m_rdy),
    .fwd         (fwd),
    .pred        (pred),
    .correct_cnt (correct_cnt),
    .done        (done),
    .proto_err   (proto_err)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   data;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] pred;
    logic [CW-1:0] cnt;
  } done_t;

  beat_t         exp_beats [$];
  done_t         exp_done  [$];
  logic [31:0]   mbuf [OW];     // reference copy of the captured forward vector
  logic [31:0]   vals [OW];     // forward values for the next sample
  logic [CW-1:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every new error beat and every done pulse
  logic [IW-1:0] prev_idx;
  logic [31:0]   prev_data;
  logic          prev_fwd;
  logic          prev_mrdy;
  initial begin
    beat_t b;
    done_t d;
    prev_idx  = IW'(OW - 1);
    prev_data = 32'h0;
    prev_fwd  = 1'b1;
    prev_mrdy = 1'b1;
    forever begin
      @(negedge clk);
      if (fwd == 1'b0 && prev_fwd == 1'b0 && prev_mrdy == 1'b0) begin
        check("stall_hold_idx", 64'(m_idx), 64'(prev_idx));
        check("stall_hold_data", 64'(m_data), 64'(prev_data));
      end else if (fwd == 1'b0 && m_idx != prev_idx) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got idx %0d data %0h expected no beat", m_idx, m_data);
        end else begin
          b = exp_beats.pop_front();
          check("beat_idx", 64'(m_idx), 64'(b.idx));
          check("beat_data", 64'(m_data), 64'(b.data));
        end
      end
      if (done == 1'b1) begin
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          d = exp_done.pop_front();
          check("done_pred", 64'(pred), 64'(d.pred));
          check("done_cnt", 64'(correct_cnt), 64'(d.cnt));
        end
      end
      prev_idx  = m_idx;
      prev_data = m_data;
      prev_fwd  = fwd;
      prev_mrdy = m_rdy;
    end
  end

  // Build expectations from vals, then issue label and forward beats
  task automatic start_sample(input logic [IW-1:0] lbl, input int skip);
    logic [31:0] maxv;
    int          p;
    bit          got [OW];
    beat_t       b;
    done_t       d;
    maxv = 32'h0;
    for (int i = 0; i < OW; i++) begin
      got[i] = (i != skip);
      if (got[i]) begin
        mbuf[i] = vals[i][31] ? 32'h0 : vals[i];
        if (mbuf[i] > maxv) maxv = mbuf[i];
      end
    end
    p = 0;
    if (maxv != 32'h0) begin
      for (int i = OW - 1; i >= 0; i--) begin
        if (got[i] && mbuf[i] == maxv) p = i;
      end
    end
    for (int k = 0; k < OW; k++) begin
      b.idx  = IW'(k);
      b.data = mbuf[k] - ((k == int'(lbl)) ? 32'h0001_0000 : 32'h0);
      exp_beats.push_back(b);
    end
    if (p == int'(lbl)) m_cnt = m_cnt + 16'd1;
    d.pred = IW'(p);
    d.cnt  = m_cnt;
    exp_done.push_back(d);

    @(posedge clk); #1;
    check("idle_fwd", 64'(fwd), 64'd1);
    check("idle_s_rdy", 64'(s_rdy), 64'd0);
    label       = lbl;
    label_valid = 1'b1;
    m_rdy       = 1'b1;
    @(posedge clk); #1;
    label_valid = 1'b0;
    label       = IW'($urandom);
    check("s_rdy_rise", 64'(s_rdy), 64'd1);
    for (int i = 0; i < OW; i++) begin
      if (i == skip) continue;
      s_valid = 1'b0;
      s_data  = $urandom;
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_idx   = IW'(i);
      s_data  = vals[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // Error phase with chosen m_rdy pattern, then the drain handshake
  task automatic finish_sample(input int stall_mode);
    int cyc;
    cyc = 0;
    while (exp_beats.size() != 0 && cyc < 200) begin
      case (stall_mode)
        0:       m_rdy = 1'b1;
        1: begin
          m_rdy       = ($urandom_range(0, 3) != 0);
          s_valid     = 1'($urandom_range(0, 1));
          s_idx       = IW'($urandom_range(0, OW - 1));
          s_data      = $urandom;
          label_valid = 1'($urandom_range(0, 1));
          label       = IW'($urandom);
        end
        2:       m_rdy = !(cyc >= 4 && cyc < 7);
        default: m_rdy = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL emit_timeout: got %0d beats outstanding expected 0", exp_beats.size());
    end
    label_valid = 1'b0;
    s_valid     = 1'b0;
    m_rdy       = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_single", 64'(done), 64'd0);
    check("fwd_after_done", 64'(fwd), 64'd1);
  endtask

  task automatic rand_vals();
    for (int i = 0; i < OW; i++) vals[i] = $urandom;
  endtask

  initial begin
    int cyc;
    rst         = 1'b1;
    label_valid = 1'b0;
    label       = '0;
    s_valid     = 1'b0;
    s_idx       = '0;
    s_data      = 32'h0;
    m_rdy       = 1'b1;
    m_cnt       = '0;
    for (int i = 0; i < OW; i++) mbuf[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_fwd", 64'(fwd), 64'd1);
    check("rst_s_rdy", 64'(s_rdy), 64'd0);
    check("rst_m_idx", 64'(m_idx), 64'(OW - 1));
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_pred", 64'(pred), 64'd0);
    check("rst_cnt", 64'(correct_cnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);

    // Correct prediction
    for (int i = 0; i < OW; i++) vals[i] = 32'h0;
    vals[0] = 32'h0000_199A; vals[1] = 32'h0000_3333;
    vals[2] = 32'h0000_4CCD; vals[3] = 32'h0000_E667;
    start_sample(IW'(3), -1);
    finish_sample(0);
    check("tc_correct_pred", 64'(pred), 64'd3);
    check("tc_correct_cnt", 64'(correct_cnt), 64'd1);

    // Negative first beat, label on and off index 0
    rand_vals(); vals[0] = 32'hFFFF_0000;
    start_sample(IW'(0), -1);
    finish_sample(0);
    rand_vals(); vals[0] = 32'hFFFF_0000;
    start_sample(IW'(5), -1);
    finish_sample(0);

    // Tie at 2 and 5 resolves to the lower index
    for (int i = 0; i < OW; i++) vals[i] = 32'(($urandom_range(0, 32'h7FFF)));
    vals[7] = 32'h8000_1234;
    vals[2] = 32'h0000_8000; vals[5] = 32'h0000_8000;
    start_sample(IW'(5), -1);
    finish_sample(0);
    check("tc_tie_pred", 64'(pred), 64'd2);

    // Three-cycle stall mid-emit
    rand_vals();
    start_sample(IW'($urandom_range(0, OW - 1)), -1);
    finish_sample(2);

    // Randomized samples with random back-pressure and ignored-input noise
    for (int t = 0; t < 6; t++) begin
      rand_vals();
      start_sample(IW'($urandom_range(0, OW - 1)), -1);
      finish_sample(1);
    end

    // Out-of-order forward stream 0,1,3,...; flag is sticky
    rand_vals();
    start_sample(IW'(1), 2);
    finish_sample(0);
    check("proto_err_set", 64'(proto_err), 64'd1);
    rand_vals();
    start_sample(IW'(4), -1);
    finish_sample(1);
    check("proto_err_sticky", 64'(proto_err), 64'd1);

    // Reset in the middle of the error phase
    rand_vals();
    start_sample(IW'(2), -1);
    m_rdy = 1'b1;
    cyc = 0;
    while (!(fwd == 1'b0 && m_idx == IW'(3)) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL reset_wait_timeout: got m_idx %0d expected 3", m_idx);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_beats.delete();
    exp_done.delete();
    m_cnt = '0;
    for (int i = 0; i < OW; i++) mbuf[i] = 32'h0;
    check("mid_rst_fwd", 64'(fwd), 64'd1);
    check("mid_rst_m_idx", 64'(m_idx), 64'(OW - 1));
    check("mid_rst_m_data", 64'(m_data), 64'd0);
    check("mid_rst_cnt", 64'(correct_cnt), 64'd0);
    check("mid_rst_pred", 64'(pred), 64'd0);
    check("mid_rst_s_rdy", 64'(s_rdy), 64'd0);
    check("mid_rst_proto_err", 64'(proto_err), 64'd0);

    // Skipped index after reset must read back as a cleared entry
    rand_vals();
    start_sample(IW'(7), 2);
    finish_sample(0);
    check("proto_err_after_rst", 64'(proto_err), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_beats_empty", 64'(exp_beats.size()), 64'd0);
    check("scoreboard_done_empty", 64'(exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
